// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: run controller for the serial pattern detector (latch cfg, shift bits, count matches, stop on target/window/abort)
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int WIN_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [3:0]         cfg_len,
  input  logic               cfg_overlap,
  input  logic [WIN_W-1:0]   cfg_window,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [WIN_W-1:0]   bits_seen,
  output logic               done,
  output logic               timeout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] ML = 4'(MAX_LEN);
  state_t state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, sh_q, sh_d, sh_n, mask;
  logic [3:0] len_q, len_d, fill_q, fill_d, fill_n, len_c;
  logic [WIN_W-1:0] win_q, win_d, seen_q, seen_d, seen_n;
  logic [CNT_W-1:0] tgt_q, tgt_d, cnt_q, cnt_d, cnt_n;
  logic ovl_q, ovl_d, match_q, match_d, done_q, done_d, to_q, to_d;
  logic hit, tgt_hit, win_hit, go;
  assign len_c   = cfg_len == 4'd0 ? 4'd1 : (cfg_len > ML ? ML : cfg_len);
  assign sh_n    = {sh_q[MAX_LEN-2:0], bit_in};
  assign fill_n  = fill_q == ML ? ML : fill_q + 4'd1;
  assign seen_n  = &seen_q ? seen_q : seen_q + WIN_W'(1);
  assign mask    = ~({MAX_LEN{1'b1}} << len_q);
  assign hit     = ((sh_n ^ pat_q) & mask) == '0 && fill_n >= len_q;
  assign cnt_n   = hit && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  assign tgt_hit = tgt_q != '0 && cnt_n == tgt_q;
  assign win_hit = win_q != '0 && seen_n == win_q;
  assign go      = start && !abort && state_q != RUN;
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    win_d   = win_q;
    tgt_d   = tgt_q;
    sh_d    = sh_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    done_d  = done_q;
    to_d    = to_q;
    match_d = 1'b0;
    if (go) begin
      state_d = RUN;
      pat_d   = cfg_pattern;
      len_d   = len_c;
      ovl_d   = cfg_overlap;
      win_d   = cfg_window;
      tgt_d   = cfg_target;
      sh_d    = '0;
      fill_d  = '0;
      cnt_d   = '0;
      seen_d  = '0;
      done_d  = 1'b0;
      to_d    = 1'b0;
    end else if (abort && state_q != IDLE) begin
      state_d = IDLE;
      done_d  = 1'b0;
      to_d    = 1'b0;
    end else if (state_q == RUN && bit_valid) begin
      sh_d    = sh_n;
      fill_d  = hit && !ovl_q ? 4'd0 : fill_n;
      seen_d  = seen_n;
      cnt_d   = cnt_n;
      match_d = hit;
      if (tgt_hit || win_hit) begin
        state_d = DONE;
        done_d  = 1'b1;
        to_d    = win_hit && !tgt_hit;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      win_q   <= '0;
      tgt_q   <= '0;
      sh_q    <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      seen_q  <= '0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      tgt_q   <= tgt_d;
      sh_q    <= sh_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      to_q    <= to_d;
      match_q <= match_d;
    end
  end
  assign busy      = state_q == RUN;
  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign bits_seen = seen_q;
  assign done      = done_q;
  assign timeout   = to_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: random and directed stimulus against a bit-history reference model
module tb_seq_det_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic cfg_overlap = 1'b0;
  logic [15:0] cfg_window = '0;
  logic [7:0] cfg_target = '0;
  logic start = 1'b0, abort = 1'b0, bit_in = 1'b0, bit_valid = 1'b0;
  logic busy, match, done, timeout;
  logic [7:0] match_cnt;
  logic [15:0] bits_seen;
  int n_chk = 0, n_pass = 0;
  int m_st, m_len, m_win, m_tgt, m_last, m_cnt, m_seen;
  logic [7:0] m_pat;
  bit m_ovl, m_match, m_done, m_to;
  int hist[$];
  always #5 clk = ~clk;
  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_window(cfg_window), .cfg_target(cfg_target),
    .start(start), .abort(abort), .bit_in(bit_in), .bit_valid(bit_valid),
    .busy(busy), .match(match), .match_cnt(match_cnt), .bits_seen(bits_seen),
    .done(done), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] status();
    return {4'b0, busy, match, done, timeout, match_cnt, bits_seen};
  endfunction
  function automatic logic [31:0] m_status();
    return {4'b0, m_st == 1, m_match, m_done, m_to, 8'(m_cnt), 16'(m_seen)};
  endfunction
  function automatic void m_reset();
    m_st = 0; m_len = 1; m_win = 0; m_tgt = 0; m_last = 0; m_cnt = 0; m_seen = 0;
    m_pat = '0; m_ovl = 0; m_match = 0; m_done = 0; m_to = 0;
    hist.delete();
  endfunction
  function automatic void m_begin();
    m_st = 1;
    m_pat = cfg_pattern;
    m_len = cfg_len == 0 ? 1 : (cfg_len > 8 ? 8 : int'(cfg_len));
    m_ovl = cfg_overlap; m_win = cfg_window; m_tgt = cfg_target;
    hist.delete();
    m_last = 0; m_cnt = 0; m_seen = 0; m_done = 0; m_to = 0;
  endfunction
  function automatic void m_step(bit st, bit ab, bit bv, bit b);
    int k;
    bit hit, th, wh;
    m_match = 0;
    if (m_st == 0) begin
      if (st && !ab) m_begin();
    end else if (m_st == 2) begin
      if (ab) begin m_st = 0; m_done = 0; m_to = 0; end
      else if (st) m_begin();
    end else if (ab) begin
      m_st = 0;
    end else if (bv) begin
      hist.push_back(int'(b));
      if (m_seen < 65535) m_seen++;
      k = hist.size();
      hit = (k - m_last) >= m_len;
      for (int i = 0; i < m_len; i++)
        if (hit && hist[k-1-i] != int'(m_pat[i])) hit = 0;
      if (hit) begin
        m_match = 1;
        if (m_cnt < 255) m_cnt++;
        if (!m_ovl) m_last = k;
      end
      th = m_tgt != 0 && m_cnt == m_tgt;
      wh = m_win != 0 && m_seen == m_win;
      if (th || wh) begin m_st = 2; m_done = 1; m_to = wh && !th; end
    end
  endfunction
  task automatic cyc(input string tag, input bit st, input bit ab, input bit bv, input bit b);
    start = st; abort = ab; bit_valid = bv; bit_in = b;
    @(posedge clk);
    #1;
    m_step(st, ab, bv, b);
    chk(tag, status(), m_status());
    start = 0; abort = 0; bit_valid = 0;
  endtask
  task automatic feed(input string tag, input string s);
    for (int i = 0; i < s.len(); i++) cyc(tag, 0, 0, s[i] != "x", s[i] == "1");
  endtask
  task automatic begin_run(input logic [7:0] p, input logic [3:0] l, input bit o, input logic [15:0] w, input logic [7:0] t);
    cyc("pre_abort", 0, 1, 0, 0);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_window = w; cfg_target = t;
    cyc("start", 1, 0, 0, 0);
  endtask
  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", status(), 32'h0);
    rst = 0;
    begin_run(8'b101, 3, 1, 0, 0);
    feed("ovl", "10101");
    chk("ovl_cnt", 32'(match_cnt), 2);
    chk("ovl_busy", 32'(busy), 1);
    begin_run(8'b101, 3, 0, 0, 0);
    feed("novl", "10101");
    chk("novl_cnt1", 32'(match_cnt), 1);
    feed("novl", "101");
    chk("novl_cnt2", 32'(match_cnt), 2);
    begin_run(8'b101, 3, 1, 0, 2);
    feed("tgt", "10101");
    chk("tgt_flags", {match, done, timeout, busy}, 4'b1100);
    feed("tgt_after", "101");
    chk("tgt_cnt", 32'(match_cnt), 2);
    chk("tgt_seen", 32'(bits_seen), 5);
    begin_run(8'b1111, 4, 1, 4, 0);
    feed("win", "0111");
    chk("win_flags", {done, timeout, busy}, 3'b110);
    chk("win_cnt", 32'(match_cnt), 0);
    begin_run(8'b11, 2, 1, 2, 1);
    feed("tie", "11");
    chk("tie_flags", {done, timeout}, 2'b10);
    begin_run(8'b101, 3, 1, 0, 0);
    feed("gap", "1x0x1");
    chk("gap_match", 32'(match), 1);
    chk("gap_seen", 32'(bits_seen), 3);
    begin_run(8'b101, 3, 1, 0, 0);
    feed("abort", "101");
    cyc("abort_cyc", 0, 1, 0, 0);
    chk("abort_hold", {busy, done, 6'(match_cnt), 8'(bits_seen)}, {2'b00, 6'd1, 8'd3});
    cyc("start_clr", 1, 0, 0, 0);
    chk("start_clr", {8'(match_cnt), bits_seen}, 24'h0);
    feed("abort_pend", "10");
    cyc("abort_pend", 0, 1, 1, 1);
    chk("abort_supp", {match, 8'(match_cnt)}, 9'd0);
    cyc("start_abort", 1, 1, 0, 0);
    chk("start_abort", 32'(busy), 0);
    begin_run(8'b1, 0, 1, 0, 0);
    feed("len0", "1");
    #2 rst = 1;
    #1;
    chk("rst_async", status(), 32'h0);
    m_reset();
    #1 rst = 0;
    for (int r = 0; r < 40; r++) begin
      begin_run(8'($urandom), 4'($urandom_range(0, 10)), 1'($urandom),
                $urandom_range(0, 3) == 0 ? 16'd0 : 16'($urandom_range(1, 40)),
                8'($urandom_range(0, 4)));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 9) == 0) begin
          cfg_pattern = 8'($urandom); cfg_len = 4'($urandom_range(0, 10));
          cfg_window = 16'($urandom_range(0, 20)); cfg_target = 8'($urandom_range(0, 3));
        end
        cyc("rand", $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 7, 1'($urandom));
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for the team's serial pattern-detector datapath. It latches a programmable pattern (length 1..MAX_LEN), overlap mode, observation window and match target on start. It then shifts in a qualified serial bitstream, flags each Moore-registered match and counts matches. It terminates the run on target reached, window expiry or abort, and reports status to the host/sequencer.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of match counter and target
WIN_W, 16, width of bit-window counter

Ports:
clk  in  1  clock
rst  in  1  reset
cfg_pattern  in  MAX_LEN  pattern; bit cfg_len-1 is the first bit received
cfg_len  in  4  pattern length; 0 treated as 1, >MAX_LEN clamped to MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_window  in  WIN_W  bits to observe; 0 = unlimited
cfg_target  in  CNT_W  matches to stop at; 0 = no target
start  in  1  start pulse; latches all cfg_*
abort  in  1  abort pulse
bit_in  in  1  serial data
bit_valid  in  1  bit_in qualifier
busy  out  1  high in RUN
match  out  1  one-cycle pulse per detected match
match_cnt  out  CNT_W  matches this run, saturating
bits_seen  out  WIN_W  valid bits accepted this run, saturating
done  out  1  level; run ended by target or window
timeout  out  1  valid with done; 1 = ended by window

Behaviour:
- Reset: rst is asynchronous, active-high; clock clk. On reset: state IDLE, shift register 0, fill 0, all outputs 0.
- States: IDLE, RUN, DONE.
  - IDLE --start--> RUN
  - RUN --target or window--> DONE
  - RUN --abort--> IDLE
  - DONE --start--> RUN
  - DONE --abort--> IDLE
- On start (IDLE or DONE):
  - Latch cfg_* into internal registers.
  - Clear shift register, fill, match_cnt, bits_seen, done and timeout.
  - The first bit can be accepted the cycle after start.
- start during RUN is ignored. abort in IDLE has no effect. Simultaneous start and abort: abort wins.
- A bit is accepted on a clk edge only when state == RUN and bit_valid == 1.
  - sh <= {sh[MAX_LEN-2:0], bit_in}
  - fill increments, saturating at MAX_LEN.
  - bits_seen increments, saturating.
- Hit condition (combinational on the next sh/fill): next sh[L-1:0] == pattern[L-1:0] and next fill >= L.
- Match handling (Moore, registered): match = 1 in the cycle after the completing bit's edge, for exactly one cycle. match_cnt increments on the same edge.
- Non-overlap mode (cfg_overlap = 0): on a hit, fill is cleared to 0, so the next match needs L fresh bits. Overlap mode keeps fill.
- Termination, evaluated on each accepted bit:
  - Target reached: target != 0 and the new match_cnt == target.
  - Window expired: window != 0 and the new bits_seen == window.
  - If either holds, go to DONE on that same edge; done = 1 from the same cycle match would pulse.
  - timeout = 1 only if window expired without target reached; the target wins ties.
- DONE: busy = 0, done held high, and bits are ignored until start or abort.
- Abort in RUN:
  - Return to IDLE; done and timeout stay 0.
  - match_cnt and bits_seen keep their values for readback.
  - A match pending from the abort edge is suppressed.
- Both limits 0: the run continues until abort.
- Saturating counters never wrap.
- cfg_* changes during RUN have no effect.
- Reset mid-run forces IDLE immediately with all outputs cleared.

Test Plan:
- Overlap detection: pattern=101, len=3, overlap=1, window=0, target=0; bits 1,0,1,0,1 every cycle -> match pulses 1 cycle after 3rd and 5th bits; match_cnt=2; busy=1 throughout.
- Non-overlap: same config with overlap=0; bits 1,0,1,0,1 -> single match after 3rd bit; match_cnt=1. Then bits 1,0,1 -> second match; match_cnt=2.
- Target stop: target=2, overlap=1, bits 1,0,1,0,1,1,0,1 -> done=1 and timeout=0 in the same cycle as the 2nd match. busy=0. Later bits ignored; match_cnt stays 2, bits_seen=5.
- Window expiry: pattern=1111, len=4, window=4; bits 0,1,1,1 -> done=1 and timeout=1 after 4th bit; match_cnt=0.
- Tie case: pattern=11, len=2, window=2, target=1; bits 1,1 -> done=1, timeout=0.
- bit_valid gaps: bit_valid toggled 1/0 with bits 1,x,0,x,1 -> only valid bits counted; match after 3rd valid bit; bits_seen=3.
- Abort and reset: abort mid-run -> IDLE, done=0, counters held. A new start clears the counters. rst asserted mid-run -> all outputs 0 asynchronously.
